// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: sole driver of a 32-entry x 8-bit operand stack.
// Passes external push/peek requests through while idle and runs
// stack-machine ALU operations (ADD, SUB, AND, NOT) that pop their operands,
// compute an 8-bit result and push it back.
// Optional build macro: STK_GUARD_EN adds a depth counter that blocks
// underflowing operations/peeks and overflowing pushes and pulses err.
module stack_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] opcode,
    input  logic       ext_push,
    input  logic [7:0] ext_data,
    input  logic       ext_peek,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] result,
    output logic       zero,
    output logic       stk_push,
    output logic       stk_pop,
    output logic       stk_tos,
    output logic [7:0] stk_data,
    input  logic [7:0] stk_res
);

    typedef enum logic [2:0] {
        IDLE,
        POP_A,
        WAIT_A,
        POP_B,
        WAIT_B,
        EXEC,
        PUSH,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_NOT = 2'b11
    } op_t;

    state_t     state, state_n;
    op_t        op_q;
    logic [7:0] opnd_a;
    logic [7:0] opnd_b;
    logic [7:0] alu_out;

    // Guard qualifiers; all requests are allowed when the guard is not built.
    logic start_ok;
    logic push_ok;
    logic peek_ok;

`ifdef STK_GUARD_EN
    logic [5:0] depth;
    logic       err_q;

    always_comb begin
        start_ok = (op_t'(opcode) == OP_NOT) ? (depth >= 6'd1) : (depth >= 6'd2);
        push_ok  = (depth != 6'd32);
        peek_ok  = (depth != 6'd0);
    end

    // Track stack occupancy from the strobes actually issued (at most one per cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= 6'd0;
        end else if (stk_push) begin
            depth <= depth + 6'd1;
        end else if (stk_pop) begin
            depth <= depth - 6'd1;
        end
    end

    // Register guard violations seen in IDLE so err lands on the following cycle;
    // a rejected start goes straight to DONE, so err coincides with done there.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == IDLE) &&
                     ((start && !start_ok) ||
                      (!start && ext_push && !push_ok) ||
                      (!start && !ext_push && ext_peek && !peek_ok));
        end
    end

    assign err = err_q;
`else
    assign start_ok = 1'b1;
    assign push_ok  = 1'b1;
    assign peek_ok  = 1'b1;
    assign err      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and strobe decode; strobes outside IDLE depend on state only.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_n  = state;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_tos  = 1'b0;
        stk_data = result;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = start_ok ? POP_A : DONE;
                end else if (ext_push) begin
                    stk_push = push_ok;
                    stk_data = ext_data;
                end else if (ext_peek) begin
                    stk_tos = peek_ok;
                end
            end
            POP_A: begin
                stk_pop = 1'b1;
                state_n = WAIT_A;
            end
            WAIT_A:  state_n = (op_q == OP_NOT) ? EXEC : POP_B;
            POP_B: begin
                stk_pop = 1'b1;
                state_n = WAIT_B;
            end
            WAIT_B:  state_n = EXEC;
            EXEC:    state_n = PUSH;
            PUSH: begin
                stk_push = 1'b1;
                state_n  = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // 8-bit ALU; B is the deeper entry, A the old top. Carry/borrow discarded.
    always_comb begin
        alu_out = 8'h00;
        case (op_q)
            OP_ADD:  alu_out = opnd_b + opnd_a;
            OP_SUB:  alu_out = opnd_b - opnd_a;
            OP_AND:  alu_out = opnd_b & opnd_a;
            OP_NOT:  alu_out = ~opnd_a;
            default: alu_out = 8'h00;
        endcase
    end

    // Opcode latch and operand capture from the registered stack output.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath holding registers are not reset; they are always
        // written before use, so a reset would only add fan-out on rst.
        if (state == IDLE && start) begin
            op_q <= op_t'(opcode);
        end
        if (state == WAIT_A) begin
            opnd_a <= stk_res;
        end
        if (state == WAIT_B) begin
            opnd_b <= stk_res;
        end
    end

    // Result and zero flag update only at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 8'h00;
            zero   <= 1'b1;
        end else if (state == EXEC) begin
            result <= alu_out;
            zero   <= (alu_out == 8'h00);
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a behavioural 32x8 stack model
// whose output register updates on the edge after a pop/tos strobe.
// Guard scenarios are compiled in only when STK_GUARD_EN is defined.
module tb_stack_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] opcode = 2'b00;
    logic       ext_push = 1'b0;
    logic [7:0] ext_data = 8'h00;
    logic       ext_peek = 1'b0;
    logic       busy, done, err, zero;
    logic [7:0] result;
    logic       stk_push, stk_pop, stk_tos;
    logic [7:0] stk_data;
    logic [7:0] stk_res = 8'h00;

    int checks = 0;
    int passed = 0;

    // Per-cycle recording of one operation (cycle 0 = start cycle).
    logic [9:0] rp, rpop, rtos, rdone, rbusy, rerr;
    logic [7:0] rdata [10];

    // Stack model.
    logic [7:0] mem [32];
    logic [4:0] sp = 5'd0;

    stack_op_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .ext_push (ext_push),
        .ext_data (ext_data),
        .ext_peek (ext_peek),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .zero     (zero),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_tos  (stk_tos),
        .stk_data (stk_data),
        .stk_res  (stk_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            sp <= 5'd0;
        end else if (stk_push) begin
            mem[sp] <= stk_data;
            sp      <= sp + 5'd1;
        end else if (stk_pop) begin
            stk_res <= mem[sp - 5'd1];
            sp      <= sp - 5'd1;
        end else if (stk_tos) begin
            stk_res <= mem[sp - 5'd1];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic expect_ok);
        @(negedge clk);
        ext_push = 1'b1;
        ext_data = d;
        #1;
        checks++;
        if (stk_push !== expect_ok || (expect_ok && stk_data !== d))
            $display("FAIL push_strobe: stk_push=%b stk_data=%h, want stk_push=%b data=%h",
                     stk_push, stk_data, expect_ok, d);
        else passed++;
        @(negedge clk);
        ext_push = 1'b0;
        #1;
        checks++;
        if (err !== !expect_ok)
            $display("FAIL push_err: err=%b, want %b", err, !expect_ok);
        else passed++;
    endtask

    task automatic peek(input logic [7:0] exp);
        @(negedge clk);
        ext_peek = 1'b1;
        #1;
        checks++;
        if (stk_tos !== 1'b1) $display("FAIL peek_tos: stk_tos=%b, want 1", stk_tos);
        else passed++;
        @(negedge clk);
        ext_peek = 1'b0;
        #1;
        checks++;
        if (stk_res !== exp) $display("FAIL peek_data: stk_res=%h, want %h", stk_res, exp);
        else passed++;
    endtask

    task automatic run_op(input logic [1:0] op, input logic hold, input logic [7:0] hd);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start    = (c == 0);
            opcode   = op;
            ext_push = hold && (c < 8);
            ext_data = hd;
            #1;
            rp[c]    = stk_push;
            rpop[c]  = stk_pop;
            rtos[c]  = stk_tos;
            rdone[c] = done;
            rbusy[c] = busy;
            rerr[c]  = err;
            rdata[c] = stk_data;
        end
        ext_push = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: %b want 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL rst_err: %b want 0", err); else passed++;
        checks++; if (result !== 8'h00) $display("FAIL rst_result: %h want 00", result); else passed++;
        checks++; if (zero !== 1'b1) $display("FAIL rst_zero: %b want 1", zero); else passed++;
        checks++;
        if ({stk_push, stk_pop, stk_tos} !== 3'b000)
            $display("FAIL rst_strobes: %b want 000", {stk_push, stk_pop, stk_tos});
        else passed++;
    endtask

    task automatic test_add();
        push(8'd5, 1'b1);
        push(8'd3, 1'b1);
        run_op(2'b00, 1'b0, 8'h00);
        checks++;
        if (rpop !== 10'b00_0000_1010)
            $display("FAIL add_pop_cycles: %b want 0000001010", rpop);
        else passed++;
        checks++;
        if (rp !== 10'b00_0100_0000) $display("FAIL add_push_cycle: %b want 0001000000", rp);
        else passed++;
        checks++;
        if (rdata[6] !== 8'd8) $display("FAIL add_push_data: %h want 08", rdata[6]);
        else passed++;
        checks++;
        if (rdone !== 10'b00_1000_0000) $display("FAIL add_done: %b want 0010000000", rdone);
        else passed++;
        checks++;
        if (rbusy !== 10'b00_1111_1110) $display("FAIL add_busy: %b want 0011111110", rbusy);
        else passed++;
        checks++;
        if (rtos !== 10'b0) $display("FAIL add_tos: %b want 0", rtos);
        else passed++;
        checks++;
        if (result !== 8'd8 || zero !== 1'b0)
            $display("FAIL add_result: result=%h zero=%b want 08/0", result, zero);
        else passed++;
        checks++;
        if (sp !== 5'd1 || mem[0] !== 8'd8)
            $display("FAIL add_stack: depth=%0d top=%h want 1/08", sp, mem[0]);
        else passed++;
    endtask

    task automatic test_sub();
        push(8'd3, 1'b1);
        push(8'd10, 1'b1);
        run_op(2'b01, 1'b0, 8'h00);
        checks++;
        if (result !== 8'hF9 || zero !== 1'b0)
            $display("FAIL sub_wrap: result=%h zero=%b want f9/0", result, zero);
        else passed++;
        push(8'hF9, 1'b1);
        run_op(2'b01, 1'b0, 8'h00);
        checks++;
        if (result !== 8'h00 || zero !== 1'b1)
            $display("FAIL sub_zero: result=%h zero=%b want 00/1", result, zero);
        else passed++;
    endtask

    task automatic test_not();
        push(8'h0F, 1'b1);
        run_op(2'b11, 1'b0, 8'h00);
        checks++;
        if (rpop !== 10'b00_0000_0010) $display("FAIL not_pop: %b want 0000000010", rpop);
        else passed++;
        checks++;
        if (rp !== 10'b00_0001_0000 || rdata[4] !== 8'hF0)
            $display("FAIL not_push: strobes=%b data=%h want 0000010000/f0", rp, rdata[4]);
        else passed++;
        checks++;
        if (rdone !== 10'b00_0010_0000) $display("FAIL not_done: %b want 0000100000", rdone);
        else passed++;
        checks++;
        if (result !== 8'hF0) $display("FAIL not_result: %h want f0", result);
        else passed++;
        peek(8'hF0);
    endtask

    task automatic test_and_held_push();
        push(8'h3C, 1'b1);
        push(8'hA5, 1'b1);
        run_op(2'b10, 1'b1, 8'h77);
        checks++;
        if (rp !== 10'b00_0100_0000)
            $display("FAIL and_no_extra_push: %b want 0001000000", rp);
        else passed++;
        checks++;
        if (rdata[6] !== 8'h24) $display("FAIL and_push_data: %h want 24", rdata[6]);
        else passed++;
        checks++;
        if (result !== 8'h24) $display("FAIL and_result: %h want 24", result);
        else passed++;
        checks++;
        if (sp !== 5'd4 || mem[3] !== 8'h24)
            $display("FAIL and_stack: depth=%0d top=%h want 4/24", sp, mem[3]);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int strobe_cnt;
        int busy_cnt;
        logic busy_wb;
        strobe_cnt = 0;
        busy_cnt   = 0;
        busy_wb    = 1'b0;
        push(8'd1, 1'b1);
        push(8'd2, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = (c == 0);
            rst   = (c == 4);
            #1;
            if (c == 4) busy_wb = busy;
            if (c >= 5) begin
                strobe_cnt += int'(stk_push) + int'(stk_pop) + int'(stk_tos);
                busy_cnt   += int'(busy);
            end
            if (c == 5) begin
                checks++;
                if (result !== 8'h00 || zero !== 1'b1)
                    $display("FAIL midrst_result: result=%h zero=%b want 00/1", result, zero);
                else passed++;
            end
        end
        rst = 1'b0;
        checks++;
        if (busy_wb !== 1'b1) $display("FAIL midrst_in_wait_b: busy=%b want 1", busy_wb);
        else passed++;
        checks++;
        if (busy_cnt != 0) $display("FAIL midrst_busy: busy cycles=%0d want 0", busy_cnt);
        else passed++;
        checks++;
        if (strobe_cnt != 0) $display("FAIL midrst_strobes: count=%0d want 0", strobe_cnt);
        else passed++;
    endtask

`ifdef STK_GUARD_EN
    task automatic test_guard();
        do_reset();
        push(8'd7, 1'b1);
        run_op(2'b11, 1'b0, 8'h00);
        checks++;
        if (result !== 8'hF8) $display("FAIL guard_not_ok: %h want f8", result);
        else passed++;
        run_op(2'b00, 1'b0, 8'h00);
        checks++;
        if (rdone !== 10'b00_0000_0010 || rerr !== 10'b00_0000_0010)
            $display("FAIL guard_add_done_err: done=%b err=%b want 0000000010 both", rdone, rerr);
        else passed++;
        checks++;
        if (rpop !== 10'b0 || rp !== 10'b0)
            $display("FAIL guard_add_strobes: pop=%b push=%b want none", rpop, rp);
        else passed++;
        checks++;
        if (result !== 8'hF8) $display("FAIL guard_add_result: %h want f8", result);
        else passed++;
        for (int i = 0; i < 31; i++) push(8'(i), 1'b1);
        push(8'hEE, 1'b0);
        checks++;
        if (sp !== 5'd0 || mem[31] !== 8'd30)
            $display("FAIL guard_overflow_stack: ptr=%0d top=%h want 0/1e", sp, mem[31]);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_not();
        test_and_held_push();
        test_reset_mid_op();
`ifdef STK_GUARD_EN
        test_guard();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
